// File: rtl/cdf_pipeline_if.sv
// Scratchpad and control bundle for the CDF stage of the histogram equalizer.
// master = the CDF pipeline, slave = the scratchpads and sequencing logic around it.
interface cdf_pipeline_if;
  logic         start;
  logic [127:0] m2ReadVal;
  logic [15:0]  m2ReadAddr;
  logic [15:0]  m3WriteAddr;
  logic [127:0] m3WriteVal;
  logic         m3WE;
  logic         done;
  logic         err;

  modport master (
    input  start, m2ReadVal,
    output m2ReadAddr, m3WriteAddr, m3WriteVal, m3WE, done, err
  );

  modport slave (
    output start, m2ReadVal,
    input  m2ReadAddr, m3WriteAddr, m3WriteVal, m3WE, done, err
  );
endinterface

// File: rtl/cdf_pipeline.sv
// Histogram CDF stage: walks m2 bins once per pass, accumulates the cumulative count
// and writes one equalization LUT word per bin into m3 (A -> V -> C -> W pipeline).
module cdf_pipeline #(
  parameter int          PIX_LOG2 = 6,
  parameter int          NUM_BINS = 256,
  parameter logic [15:0] TAG      = 16'hAAAA
) (
  input  logic          clock,
  input  logic          rst_n,
  cdf_pipeline_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [16:0] CDF_LIMIT = 17'(1) << PIX_LOG2;
  localparam logic [15:0] LAST_BIN  = 16'(NUM_BINS - 1);

  state_t        state_reg;
  logic [15:0]   addr_reg;
  logic [1:0]    drain_reg;
  logic          v_valid_reg;
  logic [15:0]   v_addr_reg;
  logic          c_valid_reg;
  logic [15:0]   c_addr_reg;
  logic [16:0]   cdf_reg;
  logic          err_reg;
  logic          done_reg;
  logic          we_reg;
  logic [15:0]   wr_addr_reg;
  logic [127:0]  wr_val_reg;

  logic [15:0]   cnt;
  logic [17:0]   sum;
  logic [16:0]   cdf_next;
  logic [24:0]   scaled;
  logic [24:0]   shifted;
  logic [7:0]    lut;
  logic          unused_bits;

  // Untagged words are bins nobody upstream ever wrote.
  assign cnt      = (bus.m2ReadVal[31:16] == TAG) ? bus.m2ReadVal[15:0] : 16'd0;
  assign sum      = {1'b0, cdf_reg} + {2'b00, cnt};
  assign cdf_next = sum[17] ? 17'h1FFFF : sum[16:0];

  // cdf*255 / 2^PIX_LOG2 as shift-and-subtract; 17+8 bits cannot overflow 25.
  assign scaled  = ({8'd0, cdf_reg} << 8) - {8'd0, cdf_reg};
  assign shifted = scaled >> PIX_LOG2;
  assign lut     = (shifted > 25'd255) ? 8'hFF : shifted[7:0];

  assign unused_bits = &{1'b0, bus.m2ReadVal[127:32]};

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      drain_reg   <= '0;
      v_valid_reg <= 1'b0;
      v_addr_reg  <= '0;
      c_valid_reg <= 1'b0;
      c_addr_reg  <= '0;
      cdf_reg     <= '0;
      err_reg     <= 1'b0;
      done_reg    <= 1'b0;
      we_reg      <= 1'b0;
      wr_addr_reg <= '0;
      wr_val_reg  <= '0;
    end else begin
      v_valid_reg <= (state_reg == RUN);
      v_addr_reg  <= addr_reg;
      c_valid_reg <= v_valid_reg;
      we_reg      <= c_valid_reg;

      // Accumulator feeds straight back on itself, so consecutive bins never stall.
      if (v_valid_reg) begin
        cdf_reg    <= cdf_next;
        c_addr_reg <= v_addr_reg;
        if (cdf_next > CDF_LIMIT) begin
          err_reg <= 1'b1;
        end
      end

      if (c_valid_reg) begin
        wr_addr_reg <= c_addr_reg;
        wr_val_reg  <= {64'd0, cdf_reg[15:0], 16'd0, TAG, 8'd0, lut};
      end

      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg <= RUN;
            addr_reg  <= '0;
            cdf_reg   <= '0;
            err_reg   <= 1'b0;
            done_reg  <= 1'b0;
          end
        end
        RUN: begin
          if (addr_reg == LAST_BIN) begin
            state_reg <= DRAIN;
            drain_reg <= '0;
          end else begin
            addr_reg <= addr_reg + 16'd1;
          end
        end
        DRAIN: begin
          drain_reg <= drain_reg + 2'd1;
          if (drain_reg == 2'd2) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          if (!bus.start) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.m2ReadAddr  = addr_reg;
  assign bus.m3WriteAddr = wr_addr_reg;
  assign bus.m3WriteVal  = wr_val_reg;
  assign bus.m3WE        = we_reg;
  assign bus.done        = done_reg;
  assign bus.err         = err_reg;

endmodule

// File: tb/tb_cdf_pipeline.sv
// Directed bench for cdf_pipeline: table of expected LUT words per scenario plus
// hand-written sequences for reset mid-pass, err clearing and a held start level.
module tb_cdf_pipeline;

  localparam logic [15:0] TAG = 16'hAAAA;

  typedef struct {
    int test;
    int bin;
    int cdf;
    int lut;
  } vec_t;

  logic clock;
  logic rst_n;
  cdf_pipeline_if bus ();

  cdf_pipeline dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  logic [127:0] m2 [256];
  logic [127:0] m3 [256];
  int checks;
  int errors;
  int rel;
  int wr_count;
  vec_t vecs [16];
  int   exp_err [5];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // m2 scratchpad with one-cycle registered read
  always @(posedge clock) bus.m2ReadVal <= m2[bus.m2ReadAddr[7:0]];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] lut_word(input int cdf, input int lut);
    return {64'd0, cdf[15:0], 16'd0, TAG, 8'd0, lut[7:0]};
  endfunction

  function automatic logic [127:0] tagw(input int v);
    return {96'd0, TAG, v[15:0]};
  endfunction

  // One clock; records and latency-checks any m3 write seen after the edge.
  task automatic step();
    @(negedge clock);
    rel++;
    if (bus.m3WE) begin
      wr_count++;
      check($sformatf("wr_latency rel=%0d", rel), 128'(bus.m3WriteAddr), 128'(rel - 3));
      check("we_while_done", 128'(bus.done), 128'd0);
      m3[bus.m3WriteAddr[7:0]] = bus.m3WriteVal;
    end
  endtask

  task automatic setup_mem(input int id);
    for (int i = 0; i < 256; i++) begin
      m2[i] = 128'd0;
      m3[i] = {4{32'hDEADBEEF}};
    end
    case (id)
      1: m2[5] = tagw(64);
      2: for (int k = 0; k < 64; k++) m2[k] = tagw(1);
      3: m2[10] = {96'd0, 16'h1234, 16'd50};
      4: begin m2[0] = tagw(40); m2[1] = tagw(40); end
      default: ;
    endcase
  endtask

  task automatic run_pass(input bit hold, output int done_cyc,
                          output logic early_err, output logic early_done);
    int guard;
    @(negedge clock);
    bus.start = 1'b1;
    rel = -1;
    wr_count = 0;
    step();
    early_err  = bus.err;
    early_done = bus.done;
    if (!hold) bus.start = 1'b0;
    guard = 0;
    while (!bus.done && guard < 600) begin
      step();
      guard++;
    end
    check("done_within_budget", 128'(bus.done), 128'd1);
    done_cyc = rel + 1;
  endtask

  task automatic check_table(input int id);
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].test == id) begin
        check($sformatf("t%0d_bin%0d", id, vecs[i].bin), m3[vecs[i].bin],
              lut_word(vecs[i].cdf, vecs[i].lut));
      end
    end
  endtask

  initial begin
    int   dc;
    logic ee;
    logic ed;
    checks = 0;
    errors = 0;
    rel = 0;
    wr_count = 0;
    vecs = '{
      '{1, 0, 0, 0},    '{1, 4, 0, 0},    '{1, 5, 64, 255},  '{1, 255, 64, 255},
      '{2, 0, 1, 3},    '{2, 10, 11, 43}, '{2, 31, 32, 127}, '{2, 63, 64, 255},
      '{2, 64, 64, 255}, '{2, 255, 64, 255},
      '{3, 9, 0, 0},    '{3, 10, 0, 0},   '{3, 255, 0, 0},
      '{4, 0, 40, 159}, '{4, 1, 80, 255}, '{4, 200, 80, 255}
    };
    exp_err = '{0, 0, 0, 0, 1};

    bus.start = 1'b0;
    rst_n = 1'b0;
    setup_mem(0);
    repeat (3) @(negedge clock);
    check("rst_done", 128'(bus.done), 128'd0);
    check("rst_err", 128'(bus.err), 128'd0);
    check("rst_we", 128'(bus.m3WE), 128'd0);
    check("rst_addr", 128'(bus.m2ReadAddr), 128'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clock);

    for (int t = 1; t <= 4; t++) begin
      setup_mem(t);
      run_pass(1'b0, dc, ee, ed);
      $display("pass test=%0d done_cycles=%0d writes=%0d err=%0b", t, dc, wr_count, bus.err);
      check($sformatf("t%0d_done_cycles", t), 128'(dc), 128'd260);
      check($sformatf("t%0d_writes", t), 128'(wr_count), 128'd256);
      check($sformatf("t%0d_err", t), 128'(bus.err), 128'(exp_err[t]));
      check_table(t);
    end

    // err from the saturating pass is cleared by the next start
    setup_mem(3);
    run_pass(1'b0, dc, ee, ed);
    check("err_cleared_on_start", 128'(ee), 128'd0);
    check("done_cleared_on_start", 128'(ed), 128'd0);
    check("err_after_clean_pass", 128'(bus.err), 128'd0);
    check_table(3);

    // reset in the middle of a pass, then a clean rerun from bin 0
    setup_mem(2);
    @(negedge clock);
    bus.start = 1'b1;
    rel = -1;
    step();
    bus.start = 1'b0;
    while (rel < 100) step();
    check("mid_pass_we_active", 128'(bus.m3WE), 128'd1);
    rst_n = 1'b0;
    #1;
    $display("reset at rel=%0d we=%0b done=%0b", rel, bus.m3WE, bus.done);
    check("async_rst_we", 128'(bus.m3WE), 128'd0);
    check("async_rst_done", 128'(bus.done), 128'd0);
    @(negedge clock);
    rst_n = 1'b1;
    setup_mem(2);
    run_pass(1'b0, dc, ee, ed);
    check("rerun_done_cycles", 128'(dc), 128'd260);
    check("rerun_writes", 128'(wr_count), 128'd256);
    check_table(2);

    // start held high for the whole pass: one pass, then wait in DONE
    setup_mem(1);
    run_pass(1'b1, dc, ee, ed);
    check("hold_done_cycles", 128'(dc), 128'd260);
    repeat (20) step();
    $display("hold start: writes=%0d done=%0b", wr_count, bus.done);
    check("hold_writes", 128'(wr_count), 128'd256);
    check("hold_stays_done", 128'(bus.done), 128'd1);
    check_table(1);
    bus.start = 1'b0;
    repeat (2) step();
    check("idle_keeps_done", 128'(bus.done), 128'd1);
    setup_mem(4);
    run_pass(1'b0, dc, ee, ed);
    check("restart_drops_done", 128'(ed), 128'd0);
    check("restart_err", 128'(bus.err), 128'd1);
    check_table(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
